// File: rtl/perceptron_pkg.sv
// Shared state encoding and sizing helpers for the sequential perceptron neuron.
// The optional ReLU output (PERCEPTRON_RELU_EN) uses relu_max for its saturation limit.
package perceptron_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width at which the bias plus N_IN full products cannot overflow.
    function automatic int acc_width(input int data_w, input int n_in);
        return 2 * data_w + $clog2(n_in + 1) + 1;
    endfunction

    function automatic int relu_max(input int data_w);
        return (1 << (data_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/perceptron_mac_step.sv
// One multiply-accumulate step: acc_next = acc_in + x*w.
// The full signed product is sign-extended to the accumulator width before the add.
module perceptron_mac_step
    import perceptron_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int ACC_W  = acc_width(10, 2)
) (
    input  logic signed [ACC_W-1:0]  acc_in_i,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [DATA_W-1:0] w_i,
    output logic signed [ACC_W-1:0]  acc_next_o
);

    logic signed [2*DATA_W-1:0] prod;

    assign prod       = x_i * w_i;
    assign acc_next_o = acc_in_i + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

endmodule

// File: rtl/perceptron_seq.sv
// Sequential perceptron: latches N_IN operands, does one MAC per clock, returns a step output.
// Define PERCEPTRON_RELU_EN to add the saturated ReLU output act_out.
module perceptron_seq
    import perceptron_pkg::*;
#(
    parameter int  N_IN   = 2,
    parameter int  DATA_W = 10,
    localparam int ACC_W  = acc_width(DATA_W, N_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN*DATA_W-1:0]   x_flat,
    input  logic [N_IN*DATA_W-1:0]   w_flat,
    input  logic [DATA_W-1:0]        bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     y,
    output logic signed [ACC_W-1:0]  sum_out
`ifdef PERCEPTRON_RELU_EN
    ,
    output logic [DATA_W-1:0]        act_out
`endif
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, acc_next;
    logic [N_IN*DATA_W-1:0]   x_q, x_d, w_q, w_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     y_q, y_d;
    logic signed [ACC_W-1:0]  sum_q, sum_d;
    logic signed [DATA_W-1:0] x_cur, w_cur;

    assign x_cur = x_q[int'(idx_q)*DATA_W +: DATA_W];
    assign w_cur = w_q[int'(idx_q)*DATA_W +: DATA_W];

    perceptron_mac_step #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac_step (
        .acc_in_i   (acc_q),
        .x_i        (x_cur),
        .w_i        (w_cur),
        .acc_next_o (acc_next)
    );

`ifdef PERCEPTRON_RELU_EN
    localparam logic [DATA_W-1:0] RELU_MAX = DATA_W'(relu_max(DATA_W));
    logic [DATA_W-1:0] act_q, act_d, relu_val;

    // Non-negative sum with any bit at or above the DATA_W sign position exceeds RELU_MAX.
    always_comb begin
        if (acc_next[ACC_W-1])                   relu_val = '0;
        else if (|acc_next[ACC_W-2:DATA_W-1])    relu_val = RELU_MAX;
        else                                     relu_val = acc_next[DATA_W-1:0];
    end
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        x_d         = x_q;
        w_d         = w_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        sum_d       = sum_q;
`ifdef PERCEPTRON_RELU_EN
        act_d       = act_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d     = x_flat;
                    w_d     = w_flat;
                    acc_d   = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_next;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    sum_d       = acc_next;
                    y_d         = ~acc_next[ACC_W-1];
`ifdef PERCEPTRON_RELU_EN
                    act_d       = relu_val;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered so in_ready stays low during reset and rises with the IDLE entry edge.
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            w_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= 1'b0;
            sum_q       <= '0;
`ifdef PERCEPTRON_RELU_EN
            act_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            w_q         <= w_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            sum_q       <= sum_d;
`ifdef PERCEPTRON_RELU_EN
            act_q       <= act_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign sum_out   = sum_q;
`ifdef PERCEPTRON_RELU_EN
    assign act_out   = act_q;
`endif

endmodule

// File: tb/tb_perceptron_seq.sv
// Directed bench for perceptron_seq: a default N_IN=2 instance and an N_IN=4 instance.
module tb_perceptron_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // N_IN=2 instance
    logic               in_valid, in_ready, out_valid, out_ready, y;
    logic [19:0]        x_flat, w_flat;
    logic [9:0]         bias;
    logic signed [22:0] sum_out;
    // N_IN=4 instance
    logic               in_valid4, in_ready4, out_valid4, out_ready4, y4;
    logic [39:0]        x_flat4, w_flat4;
    logic [9:0]         bias4;
    logic signed [23:0] sum_out4;
`ifdef PERCEPTRON_RELU_EN
    logic [9:0]         act_out, act_out4;
`endif

    perceptron_seq #(.N_IN(2), .DATA_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_flat(x_flat), .w_flat(w_flat), .bias(bias), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .sum_out(sum_out)
`ifdef PERCEPTRON_RELU_EN
        , .act_out(act_out)
`endif
    );

    perceptron_seq #(.N_IN(4), .DATA_W(10)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .x_flat(x_flat4), .w_flat(w_flat4), .bias(bias4), .out_valid(out_valid4),
        .out_ready(out_ready4), .y(y4), .sum_out(sum_out4)
`ifdef PERCEPTRON_RELU_EN
        , .act_out(act_out4)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a bundle on the N_IN=2 instance, scramble operands after the accepting edge,
    // and check output timing/values. Leaves the result pending in DONE.
    task automatic run2(input string tag, input int x0, x1, w0, w1, b, input longint exp_sum,
                        input logic exp_y, input int exp_act);
        x_flat   = {10'(x1), 10'(x0)};
        w_flat   = {10'(w1), 10'(w0)};
        bias     = 10'(b);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        x_flat   = '1;
        w_flat   = 20'h5A5A5;
        bias     = 10'h1FF;
        chk({tag, ".in_ready_busy"}, in_ready, 1'b0);
        tick();
        chk({tag, ".valid_early"}, out_valid, 1'b0);
        tick();
        chk({tag, ".valid"}, out_valid, 1'b1);
        chk({tag, ".sum"}, sum_out, exp_sum);
        chk({tag, ".y"}, y, exp_y);
`ifdef PERCEPTRON_RELU_EN
        chk({tag, ".act"}, act_out, exp_act);
`else
        if (exp_act < 0) $display("note: negative act expectation ignored");
`endif
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".valid_clr"}, out_valid, 1'b0);
        chk({tag, ".in_ready_back"}, in_ready, 1'b1);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        x_flat     = '0;
        w_flat     = '0;
        bias       = '0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        x_flat4    = '0;
        w_flat4    = '0;
        bias4      = '0;

        tick();
        tick();
        chk("rst.in_ready", in_ready, 1'b0);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.y", y, 1'b0);
        chk("rst.sum", sum_out, 0);
        rst_n = 1'b1;
        #1;
        chk("rel.in_ready_pre", in_ready, 1'b0);
        tick();
        chk("rel.in_ready", in_ready, 1'b1);

        // 3*2 + 4*(-1) - 2 = 0 -> y=1
        run2("t1", 3, 4, 2, -1, -2, 0, 1'b1, 0);
        drain("t1");

        // -5*3 + 1*2 + 0 = -13
        run2("t2", -5, 1, 3, 2, 0, -13, 1'b0, 0);
        drain("t2");

        // 2*262144 + 511 = 524799, saturates ReLU at 511
        run2("t3", -512, -512, -512, -512, 511, 524799, 1'b1, 511);
        drain("t3");

        // Back-pressure: result held, new bundles refused
        run2("t4", 7, -2, 3, 5, 1, 12, 1'b1, 12);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            x_flat   = {10'(9), 10'(9)};
            w_flat   = {10'(9), 10'(9)};
            tick();
            chk("hold.valid", out_valid, 1'b1);
            chk("hold.sum", sum_out, 12);
            chk("hold.y", y, 1'b1);
            chk("hold.in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        drain("t4");
        tick();
        chk("hold.no_accept", in_ready, 1'b1);
        chk("hold.no_result", out_valid, 1'b0);

        // Reset one cycle into MAC
        x_flat   = {10'(100), 10'(100)};
        w_flat   = {10'(100), 10'(100)};
        bias     = 10'(5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst.out_valid", out_valid, 1'b0);
        chk("mrst.sum", sum_out, 0);
        chk("mrst.y", y, 1'b0);
        chk("mrst.in_ready", in_ready, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("mrst.in_ready_back", in_ready, 1'b1);
        chk("mrst.no_partial", out_valid, 1'b0);
        run2("t5", 1, 1, 1, 1, 0, 2, 1'b1, 2);
        drain("t5");

        // N_IN=4: 1+2+3-40 = -34, valid exactly 4 edges after accept
        x_flat4   = {10'(4), 10'(3), 10'(2), 10'(1)};
        w_flat4   = {10'(-10), 10'(1), 10'(1), 10'(1)};
        bias4     = '0;
        in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        x_flat4   = '0;
        w_flat4   = '0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("n4.valid_early", out_valid4, 1'b0);
        end
        tick();
        chk("n4.valid", out_valid4, 1'b1);
        chk("n4.sum", sum_out4, -34);
        chk("n4.y", y4, 1'b0);
`ifdef PERCEPTRON_RELU_EN
        chk("n4.act", act_out4, 0);
`endif
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        chk("n4.valid_clr", out_valid4, 1'b0);
        chk("n4.in_ready_back", in_ready4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
